// File: rtl/ahb_bm_input_stage_pkg.sv
// Shared encodings for the bus-matrix input stage: AHB transfer types,
// responses, burst types (also used by the output arbiter) and FSM states.
package ahb_bm_input_stage_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'b000,
        HBURST_INCR   = 3'b001,
        HBURST_WRAP4  = 3'b010,
        HBURST_INCR4  = 3'b011,
        HBURST_WRAP8  = 3'b100,
        HBURST_INCR8  = 3'b101,
        HBURST_WRAP16 = 3'b110,
        HBURST_INCR16 = 3'b111
    } hburst_e;

    // IDLE: nothing outstanding, PEND: address held awaiting accept,
    // DATA: accepted, data phase running at the output stage.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PEND = 2'b01,
        ST_DATA = 2'b10
    } bm_state_e;

    // NONSEQ and SEQ are real transfers; IDLE and BUSY are not.
    function automatic logic is_transfer(input logic [1:0] htrans);
        return htrans[1];
    endfunction

endpackage

// File: rtl/ahb_bm_addr_hold.sv
// Address/control hold register for a stalled master, plus the mux that
// forwards either the live master-side signals or the held copy.
module ahb_bm_addr_hold
    import ahb_bm_input_stage_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  capture_en,
    input  logic                  use_held,
    input  logic                  HSELS,
    input  logic [ADDR_WIDTH-1:0] HADDRS,
    input  logic [1:0]            HTRANSS,
    input  logic                  HWRITES,
    input  logic [2:0]            HSIZES,
    input  logic [2:0]            HBURSTS,
    input  logic [3:0]            HPROTS,
    input  logic                  HMASTLOCKS,
    output logic [ADDR_WIDTH-1:0] HADDRM,
    output logic [1:0]            HTRANSM,
    output logic                  HWRITEM,
    output logic [2:0]            HSIZEM,
    output logic [2:0]            HBURSTM,
    output logic [3:0]            HPROTM,
    output logic                  HMASTLOCKM
);

    logic [ADDR_WIDTH-1:0] held_addr_r;
    logic [1:0]            held_trans_r;
    logic                  held_write_r;
    logic [2:0]            held_size_r;
    logic [2:0]            held_burst_r;
    logic [3:0]            held_prot_r;
    logic                  held_lock_r;

    // Track the master's address phase until a stall freezes the copy.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            held_addr_r  <= {ADDR_WIDTH{1'b0}};
            held_trans_r <= HTRANS_IDLE;
            held_write_r <= 1'b0;
            held_size_r  <= 3'b000;
            held_burst_r <= 3'b000;
            held_prot_r  <= 4'b0000;
            held_lock_r  <= 1'b0;
        end else if (capture_en) begin
            held_addr_r  <= HADDRS;
            held_trans_r <= HTRANSS;
            held_write_r <= HWRITES;
            held_size_r  <= HSIZES;
            held_burst_r <= HBURSTS;
            held_prot_r  <= HPROTS;
            held_lock_r  <= HMASTLOCKS;
        end else begin
            held_addr_r  <= held_addr_r;
            held_trans_r <= held_trans_r;
            held_write_r <= held_write_r;
            held_size_r  <= held_size_r;
            held_burst_r <= held_burst_r;
            held_prot_r  <= held_prot_r;
            held_lock_r  <= held_lock_r;
        end
    end

    // Replay the held phase while stalled, otherwise pass live signals through.
    always_comb begin
        HADDRM     = HADDRS;
        HTRANSM    = HTRANSS;
        HWRITEM    = HWRITES;
        HSIZEM     = HSIZES;
        HBURSTM    = HBURSTS;
        HPROTM     = HPROTS;
        HMASTLOCKM = HMASTLOCKS;
        if (use_held) begin
            HADDRM     = held_addr_r;
            HTRANSM    = held_trans_r;
            HWRITEM    = held_write_r;
            HSIZEM     = held_size_r;
            HBURSTM    = held_burst_r;
            HPROTM     = held_prot_r;
            HMASTLOCKM = held_lock_r;
        end else if (!HSELS) begin
            HTRANSM = HTRANS_IDLE;
        end else begin
            HTRANSM = HTRANSS;
        end
    end

endmodule

// File: rtl/ahb_bm_input_stage.sv
// Bus-matrix input stage for one master port: raises the transfer request,
// stalls the master while the output stage is busy and replays the held
// address phase once accepted.
module ahb_bm_input_stage
    import ahb_bm_input_stage_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSELS,
    input  logic [ADDR_WIDTH-1:0] HADDRS,
    input  logic [1:0]            HTRANSS,
    input  logic                  HWRITES,
    input  logic [2:0]            HSIZES,
    input  logic [2:0]            HBURSTS,
    input  logic [3:0]            HPROTS,
    input  logic                  HMASTLOCKS,
    input  logic                  HREADYS,
    input  logic                  active_trans,
    input  logic                  HREADYM,
    input  logic                  HRESPM,
    output logic                  trans_pend,
    output logic [ADDR_WIDTH-1:0] HADDRM,
    output logic [1:0]            HTRANSM,
    output logic                  HWRITEM,
    output logic [2:0]            HSIZEM,
    output logic [2:0]            HBURSTM,
    output logic [3:0]            HPROTM,
    output logic                  HMASTLOCKM,
    output logic                  HREADYOUTS,
    output logic                  HRESPS
);

    bm_state_e state_r;
    bm_state_e next_state_s;
    logic      new_s;
    logic      acc_s;
    logic      req_live_s;
    logic      capture_en_s;
    logic      use_held_s;

    assign req_live_s   = HSELS & is_transfer(HTRANSS);
    assign new_s        = req_live_s & HREADYS;
    assign acc_s        = active_trans & HREADYM;
    assign use_held_s   = (state_r == ST_PEND);
    assign capture_en_s = HREADYS & (state_r != ST_PEND);

    // State register with asynchronous return to IDLE.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next state: a live transfer accepted in the same cycle skips PEND.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (new_s && acc_s)      next_state_s = ST_DATA;
                else if (new_s)          next_state_s = ST_PEND;
                else                     next_state_s = ST_IDLE;
            end
            ST_PEND: begin
                if (acc_s)               next_state_s = ST_DATA;
                else                     next_state_s = ST_PEND;
            end
            ST_DATA: begin
                if (!HREADYM)            next_state_s = ST_DATA;
                else if (new_s && acc_s) next_state_s = ST_DATA;
                else if (new_s)          next_state_s = ST_PEND;
                else                     next_state_s = ST_IDLE;
            end
            default:                     next_state_s = bm_state_e'(2'bxx);
        endcase
    end

    // Request, ready and response back towards master and arbiters.
    always_comb begin
        trans_pend = req_live_s;
        HREADYOUTS = 1'b1;
        HRESPS     = HRESP_OKAY;
        case (state_r)
            ST_IDLE: begin
                trans_pend = req_live_s;
                HREADYOUTS = 1'b1;
                HRESPS     = HRESP_OKAY;
            end
            ST_PEND: begin
                trans_pend = 1'b1;
                HREADYOUTS = 1'b0;
                HRESPS     = HRESP_OKAY;
            end
            ST_DATA: begin
                trans_pend = req_live_s;
                HREADYOUTS = HREADYM;
                HRESPS     = HRESPM;
            end
            default: begin
                trans_pend = 1'bx;
                HREADYOUTS = 1'bx;
                HRESPS     = 1'bx;
            end
        endcase
    end

    ahb_bm_addr_hold #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_hold (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .capture_en (capture_en_s),
        .use_held   (use_held_s),
        .HSELS      (HSELS),
        .HADDRS     (HADDRS),
        .HTRANSS    (HTRANSS),
        .HWRITES    (HWRITES),
        .HSIZES     (HSIZES),
        .HBURSTS    (HBURSTS),
        .HPROTS     (HPROTS),
        .HMASTLOCKS (HMASTLOCKS),
        .HADDRM     (HADDRM),
        .HTRANSM    (HTRANSM),
        .HWRITEM    (HWRITEM),
        .HSIZEM     (HSIZEM),
        .HBURSTM    (HBURSTM),
        .HPROTM     (HPROTM),
        .HMASTLOCKM (HMASTLOCKM)
    );

endmodule
